// File: rtl/lvdt_pkg.sv
// Shared types and default widths for the LVDT excitation scheduler.
package lvdt_pkg;
   localparam int LVDT_DIV_W   = 5;
   localparam int LVDT_DWELL_W = 8;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   // Divider configuration as offered on the cfg bus and held in the shadow.
   typedef struct packed {
      logic                    sweep;
      logic [LVDT_DIV_W-1:0]   lo;
      logic [LVDT_DIV_W-1:0]   hi;
      logic [LVDT_DWELL_W-1:0] dwell;
   } cfg_t;
endpackage

// File: rtl/lvdt_exc_sched_if.sv
// Configuration handshake bus into the excitation scheduler.
interface lvdt_exc_sched_if
   import lvdt_pkg::*;
#(
   parameter int DIV_W   = LVDT_DIV_W,
   parameter int DWELL_W = LVDT_DWELL_W
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic               cfg_sweep;
   logic [DIV_W-1:0]   cfg_lo;
   logic [DIV_W-1:0]   cfg_hi;
   logic [DWELL_W-1:0] cfg_dwell;

   modport master (output cfg_valid, cfg_sweep, cfg_lo, cfg_hi, cfg_dwell, input cfg_ready);
   modport slave  (input cfg_valid, cfg_sweep, cfg_lo, cfg_hi, cfg_dwell, output cfg_ready);
endinterface

// File: rtl/lvdt_reload_div.sv
// Reload divider: counts up, tick on the MSB, reloads instead of incrementing.
module lvdt_reload_div
   import lvdt_pkg::*;
#(
   parameter int DIV_W = LVDT_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             tick
);
   logic [DIV_W:0] cnt_q, cnt_d;

   assign tick = cnt_q[DIV_W];

   // Clear when stopped, reload on request, otherwise count.
   always_comb begin
      cnt_d = cnt_q + (DIV_W+1)'(1);
      if (!run)
         cnt_d = '0;
      else if (load)
         cnt_d = {1'b0, load_val};
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/lvdt_exc_sched.sv
// Excitation scheduler: FSM, config shadow, sweep dwell and settle tracking.
module lvdt_exc_sched
   import lvdt_pkg::*;
#(
   parameter int DIV_W        = LVDT_DIV_W,
   parameter int DWELL_W      = LVDT_DWELL_W,
   parameter int SETTLE_TICKS = 4
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic             enable,
   lvdt_exc_sched_if.slave  cfg,
   output logic             tick,
   output logic [DIV_W-1:0] cur_div,
   output logic             settled,
   output logic             busy
);
   // Shadow and active config use the package struct, so DIV_W/DWELL_W
   // overrides must be matched by the package widths.
   localparam int SET_W = $clog2(SETTLE_TICKS + 1);
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_TICKS);

   state_e             state_q, state_d;
   cfg_t               shadow_q, shadow_d, act_q, act_d;
   logic               pending_q, pending_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_eff;
   logic [DWELL_W:0]   dwell_nx;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               raw_tick, accept, apply, sweep_on, step;

   lvdt_reload_div #(.DIV_W(DIV_W)) u_div (
      .clk      (mclk),
      .rst_n    (reset),
      .run      (enable),
      .load     (tick | (state_q == IDLE)),
      .load_val (div_d),
      .tick     (raw_tick)
   );

   assign tick          = raw_tick & enable & (state_q == RUN);
   assign cfg.cfg_ready = !pending_q;
   assign accept        = cfg.cfg_valid && !pending_q;
   // Applied at a reload, on leaving RUN, or at once while idle.
   assign apply         = pending_q && ((state_q == IDLE) || !enable || tick);
   assign sweep_on      = act_q.sweep && (act_q.lo < act_q.hi);
   assign dwell_eff     = (act_q.dwell == '0) ? DWELL_W'(1) : act_q.dwell;
   assign dwell_nx      = {1'b0, dwell_q} + (DWELL_W+1)'(1);
   assign step          = tick && sweep_on && (dwell_nx >= {1'b0, dwell_eff});
   assign cur_div       = div_q;
   assign busy          = (state_q == RUN);
   assign settled       = (settle_q == SETTLE_MAX) && (state_q == RUN);

   // Run/idle follows enable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shadow capture, config apply, sweep stepping and settle counting.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      act_d     = act_q;
      div_d     = div_q;
      dwell_d   = dwell_q;
      settle_d  = settle_q;
      if (accept) begin
         shadow_d.sweep = cfg.cfg_sweep;
         shadow_d.lo    = cfg.cfg_lo;
         shadow_d.hi    = cfg.cfg_hi;
         shadow_d.dwell = cfg.cfg_dwell;
         pending_d      = 1'b1;
      end
      if (apply) begin
         pending_d = 1'b0;
         act_d     = shadow_q;
         div_d     = shadow_q.lo;
         dwell_d   = '0;
         settle_d  = '0;
      end else begin
         if (!enable)
            dwell_d = '0;
         else if (step) begin
            dwell_d = '0;
            div_d   = (div_q >= act_q.hi) ? act_q.lo : div_q + DIV_W'(1);
         end else if (tick && sweep_on)
            dwell_d = dwell_nx[DWELL_W-1:0];
         if (div_d != div_q)
            settle_d = '0;
         else if (tick && (settle_q != SETTLE_MAX))
            settle_d = settle_q + SET_W'(1);
      end
   end

   // State registers; an unapplied config is dropped by reset.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         act_q     <= '0;
         pending_q <= 1'b0;
         div_q     <= '0;
         dwell_q   <= '0;
         settle_q  <= '0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         act_q     <= act_d;
         pending_q <= pending_d;
         div_q     <= div_d;
         dwell_q   <= dwell_d;
         settle_q  <= settle_d;
      end
   end
endmodule

// File: doc/lvdt_exc_sched.md
# lvdt_exc_sched

Excitation-frequency scheduler for the LVDT front end. Owns the programmable reload divider that turns `mclk` into the excitation tick, and accepts new divider settings through a valid/ready handshake. Changes are applied only on a tick boundary, so the excitation waveform never gets a truncated period. Optionally sweeps the divider between two limits for frequency characterisation of the transducer.

## Interface
- `DIV_W`, 5: width of the divider reload value; the internal counter is `DIV_W+1` bits.
- `DWELL_W`, 8: width of the sweep dwell count.
- `SETTLE_TICKS`, 4: ticks at an unchanged divider before `settled` asserts.

- `mclk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run the divider; low holds it idle.
- `cfg_valid` in 1: a configuration is offered.
- `cfg_ready` out 1: a configuration can be accepted.
- `cfg_sweep` in 1: 0 selects fixed mode at `cfg_lo`; 1 selects sweep mode.
- `cfg_lo` in `DIV_W`: fixed divider value, or the sweep start value.
- `cfg_hi` in `DIV_W`: sweep end value.
- `cfg_dwell` in `DWELL_W`: ticks per sweep step; 0 is treated as 1.
- `tick` out 1: one-cycle excitation pulse.
- `cur_div` out `DIV_W`: divider value currently in effect.
- `settled` out 1: the divider has been stable for `SETTLE_TICKS` ticks.
- `busy` out 1: the block is in the RUN state.

## Operation
- **Divider.**
  - A `DIV_W+1`-bit counter `cnt` increments every cycle while running.
  - `tick` = `cnt[DIV_W]`, decoded combinationally from `cnt`.
  - When `tick` is high, the next edge loads `cnt` with the next divider value instead of incrementing.
  - Resulting period is 2^DIV_W + 1 − D cycles: D=0 gives 33 cycles, D=31 gives 2 cycles.
- **FSM states.**
  - IDLE: `cnt`=0, `tick`=0. IDLE → RUN when `enable`=1, and `cnt` loads `cur_div` on that edge.
  - RUN → IDLE when `enable`=0, and `cnt` clears on that edge.
- **Configuration handshake.**
  - Transfer occurs when `cfg_valid` && `cfg_ready`; the fields are captured into a shadow register and a pending flag is set.
  - `cfg_ready` = !pending.
  - In RUN, the shadow is applied at the first reload edge strictly after acceptance. A config accepted in a `tick` cycle is applied at the following tick.
  - In IDLE, the shadow is applied on the edge after acceptance.
  - Applying the shadow clears pending, sets the mode, sets `cur_div`=`cfg_lo`, and clears the dwell and settle counters.
- **Sweep mode.**
  - A dwell counter counts ticks. After `max(cfg_dwell,1)` ticks at one value, the reload uses `cur_div`+1.
  - After `cfg_hi`, the sweep wraps to `cfg_lo`.
  - If `cfg_lo` ≥ `cfg_hi`, sweep mode behaves as fixed mode at `cfg_lo`.
  - A pending config takes priority over a sweep step at the same reload.
- **Settle.**
  - The settle counter saturates at `SETTLE_TICKS`.
  - It clears whenever `cur_div` changes and counts ticks otherwise.
  - `settled` = (count == `SETTLE_TICKS`) && RUN.
- **Enable drop mid-period.** `cnt` clears, no `tick` is issued, and the dwell counter clears. `cur_div` and the mode are retained, and a pending config is applied immediately.
- **Reset values.** `cnt`=0, `cur_div`=0, mode=fixed, pending=0, `tick`=0, `cfg_ready`=1, `settled`=0, `busy`=0, FSM=IDLE.
- **Reset mid-operation.** All registers clear asynchronously and an accepted-but-unapplied config is discarded.

## Timing
- `tick` goes high in the cycle in which `cnt` = 2^DIV_W. It is never high for two consecutive cycles.
- First `tick` after IDLE→RUN (edge k) appears in cycle k + 2^DIV_W − D.
- `cur_div` updates on the same edge as the reload that uses the new value.
- `cfg_ready` falls on the edge after acceptance. It rises on the edge on which the shadow is applied.
- There are no combinational paths from `cfg_*` to any output.

## Structure
- A shared package `lvdt_pkg` holds:
  - `DIV_W` and `DWELL_W` defaults;
  - the FSM state enum {IDLE, RUN};
  - a config struct {sweep, lo, hi, dwell}.
- One sub-module, `lvdt_reload_div`: the counter with an active-low async reset, inputs `run` and `load_val`, and output `tick`.
- The scheduler (FSM, shadow register, dwell and settle counters) is the top level, `lvdt_exc_sched`.

## Test plan
- Fixed D=28, `enable`=1: `tick` every 5 cycles; `settled` rises on the 4th tick.
- D=0: `tick` period 33. Then a config of D=31 accepted mid-period: the current period completes at 33, after which the periods are 2. `cur_div` changes exactly at the reload edge.
- Sweep lo=29, hi=31, dwell=2: `cur_div` sequence per tick is 29,29,30,30,31,31,29…
  - dwell=0 behaves as dwell=1.
  - lo=31, hi=29 holds at 31.
- Back-pressure: hold `cfg_valid` with two configs back-to-back. The second is accepted only after the first applies, and `cfg_ready`=0 in between.
- Deassert `enable` with a config pending: `tick` stops, `cnt`=0, the config applies next edge. Re-enabling gives the first `tick` at 2^5 − D cycles.
- Assert `reset` mid-period with a config pending: all outputs return to their reset values immediately, `cfg_ready`=1, and the pending config is lost.
